alu_responder: RTL and testbench
================================

# alu_responder

Datapath-side responder for the arithmetic sequencing controller. Services the controller's level enables for operand A, operand B, remainder and result: it fetches operands from the operand ROM, runs add/sub or iterative multiply/divide, latches outputs, and returns a one-cycle done pulse per request. It sits between the controller, the synchronous operand ROM and the result display registers.

## Interface
- `ROM_AW`, default 9: ROM address width; matches the controller's `Endereco`.
- `DW`, default 8: operand width. The result is 2*DW wide.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en_a`, `en_b`, `en_resto`, `en_c` in 1 each: request levels from the controller.
- `op_sel` in 2: 00 add, 01 sub, 10 mul, 11 div. Sampled when a B request is accepted.
- `endereco` in ROM_AW: ROM word address. Sampled when an A or B request is accepted.
- `rom_addr` out ROM_AW: registered address to the ROM.
- `rom_data` in DW: ROM data, valid one cycle after `rom_addr`.
- `a_q`, `b_q` out DW: latched operands.
- `quociente` out 2*DW: running accumulator (sum, difference, product or quotient).
- `resto_q` out DW: latched remainder.
- `c_q` out 2*DW: latched final result.
- `fim_a`, `fim_b`, `fim_resto`, `fim_c` out 1 each: one-cycle done pulses.
- `div_err` out 1: present only with ALU_RESP_ERR_EN.

## Operation
- **States:** IDLE, RD_A, CAP_A, RD_B, CAP_B, EXEC, RESTO, WR_C.
- **Arming:** each enable has an armed flag.
  - Reset sets the flag to 1.
  - Servicing a request clears it.
  - The enable being low re-sets it.
  - A request is accepted only in IDLE while its enable is high and armed. An enable held high therefore never retriggers.
- **Priority:** when several requests are pending in IDLE, the order is A > B > RESTO > C. Requests that rise while the block is busy are serviced after it returns to IDLE, provided they are still high.
- **A request:** IDLE → RD_A (`rom_addr`<=`endereco`) → CAP_A (`a_q`<=`rom_data`, `fim_a`<=1) → IDLE.
- **B request:** IDLE → RD_B → CAP_B (`b_q`<=`rom_data`, latch `op_sel`) → EXEC → IDLE. `fim_b` pulses when EXEC completes.
- **EXEC arithmetic:**
  - Operands are zero-extended to 2*DW.
  - Add: `quociente` = A+B, done in 1 cycle.
  - Sub: `quociente` = A−B mod 2^(2*DW), done in 1 cycle.
  - Mul: repeated addition. The accumulator starts at 0 and the counter starts at B. Each cycle adds A and decrements the counter, finishing when the counter is 0. B=0 finishes in 1 cycle with 0.
  - Div: repeated subtraction. The remainder starts at A and the quotient at 0. Each cycle, if rem ≥ B, subtract B and increment the quotient; otherwise finish. A<B or A=0 gives quotient 0 and remainder A.
  - Div with B=0: quotient 0, remainder A, finish in 1 cycle.
- **RESTO request:** `resto_q`<=remainder and `fim_resto`<=1, in 1 cycle. For non-div ops the remainder is 0.
- **C request:** `c_q`<=`quociente` and `fim_c`<=1, in 1 cycle.
- **Reset:** drives every output to 0 and the state to IDLE, including during EXEC. Any partial result is discarded and no `fim_*` pulse is issued.

## Timing
- A or B request high at rising edge k, in IDLE and armed:
  - `rom_addr` is valid after edge k.
  - The operand is captured at edge k+2.
  - `fim_a` is high for the cycle after edge k+2.
- `fim_b` timing by operation:
  - Add/sub: high after edge k+3.
  - Mul: high after edge k+3+max(B−1,0).
  - Div: high after edge k+3+Q, where Q is the quotient.
- RESTO and C: the output register and `fim` are updated at edge k+1.
- Each `fim_*` is exactly one cycle wide. At most one `fim_*` is high in any cycle.
- `quociente` updates every EXEC cycle. It is valid when `fim_b` is high and holds until the next B request.

## Configuration
- **ALU_RESP_ERR_EN defined:**
  - `div_err` is set in the EXEC finish cycle of a divide with B=0.
  - It is cleared at the start of the next B request or on reset.
  - Quotient and remainder behave the same as without the macro.
- **ALU_RESP_ERR_EN undefined:** the `div_err` port and its logic are absent.

## Structure
- **Package `alu_resp_pkg`:** state enum, `op_sel` encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV), default widths.
- **Sub-module `iter_muldiv`:**
  - Inputs: start, op, a, b.
  - Outputs: busy, done, acc, rem.
  - Contains the mul/div counter loop and the 1-cycle add/sub.
  - The top level contains the request FSM, arming logic, ROM interface and output registers.

## Test plan
- ROM[0]=7, ROM[2]=5, op add: assert `en_a` with addr 0, then `en_b` with addr 2 → `fim_a` 2 cycles after acceptance, `a_q`=7. `fim_b` 3 cycles after acceptance, `quociente`=12. `en_c` → `c_q`=12.
- A=3, B=5, op sub → `quociente`=16'hFFFE.
- A=255, B=255, op mul → `quociente`=65025, `fim_b` 257 cycles after B acceptance. Separately, B=0 → `quociente`=0 with 3-cycle latency.
- A=200, B=7, op div → `quociente`=28, `resto_q`=4 after `en_resto`. B=0 → `quociente`=0, `resto_q`=200, and `div_err`=1 when the macro is defined.
- Arming and priority:
  - `en_a` and `en_c` rise together → A is serviced first, then C.
  - An enable held high across 3 services yields only one `fim`.
- `rst_n` pulsed low mid-multiply (B=100) → all outputs 0 immediately, no `fim_b`, and a fresh request completes correctly.

Source files
------------

// File: rtl/alu_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_resp_pkg
// Description : Shared types and defaults for the alu_responder block:
//               FSM state enum, op_sel encodings and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_resp_pkg;

    localparam int DEF_ROM_AW = 9;
    localparam int DEF_DW     = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_CAP_A = 3'd2,
        S_RD_B  = 3'd3,
        S_CAP_B = 3'd4,
        S_EXEC  = 3'd5,
        S_RESTO = 3'd6,
        S_WR_C  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder_if
// Description : Controller <-> responder handshake: request levels, opcode,
//               ROM word address and the one-cycle done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_responder_if #(
    parameter int ROM_AW = 9
);
    logic              en_a;
    logic              en_b;
    logic              en_resto;
    logic              en_c;
    logic [1:0]        op_sel;
    logic [ROM_AW-1:0] endereco;
    logic              fim_a;
    logic              fim_b;
    logic              fim_resto;
    logic              fim_c;

    // Controller side
    modport master (
        output en_a, en_b, en_resto, en_c, op_sel, endereco,
        input  fim_a, fim_b, fim_resto, fim_c
    );

    // Datapath responder side
    modport slave (
        input  en_a, en_b, en_resto, en_c, op_sel, endereco,
        output fim_a, fim_b, fim_resto, fim_c
    );
endinterface
`default_nettype wire

// File: rtl/alu_responder_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iter_muldiv
// Description : Single-cycle add/sub and iterative multiply (repeated add)
//               / divide (repeated subtract). done is asserted during the
//               final busy cycle; acc/rem hold their final values after it.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_muldiv
    import alu_resp_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire op_t           op,
    input  wire logic [DW-1:0] a,
    input  wire logic [DW-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [2*DW-1:0]    acc,
    output logic [DW-1:0]      rem
);

    localparam logic [2*DW-1:0] C_ACC_ONE = {{(2*DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   C_CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    op_t            op_r;
    logic [DW-1:0]  a_r;
    logic [DW-1:0]  b_r;
    logic [DW-1:0]  cnt_r;
    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;

    assign a_ext = {{DW{1'b0}}, a_r};
    assign b_ext = {{DW{1'b0}}, b_r};

    // Final-cycle detection: mul ends on the last add (or at once for B=0),
    // div ends on the first cycle where no further subtraction fits.
    always_comb begin
        done = 1'b0;
        if (busy) begin
            case (op_r)
                OP_ADD:  done = 1'b1;
                OP_SUB:  done = 1'b1;
                OP_MUL:  done = (cnt_r <= C_CNT_ONE);
                OP_DIV:  done = (b_r == '0) || (rem < b_r);
                default: done = 1'b1;
            endcase
        end
    end

    // Operand capture on start, then one arithmetic step per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            op_r  <= OP_ADD;
            a_r   <= '0;
            b_r   <= '0;
            cnt_r <= '0;
            acc   <= '0;
            rem   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            cnt_r <= b;
            acc   <= '0;
            rem   <= (op == OP_DIV) ? a : '0;
        end else if (busy) begin
            case (op_r)
                OP_ADD: acc <= a_ext + b_ext;
                OP_SUB: acc <= a_ext - b_ext;
                OP_MUL: begin
                    if (cnt_r != '0) begin
                        acc   <= acc + a_ext;
                        cnt_r <= cnt_r - C_CNT_ONE;
                    end
                end
                OP_DIV: begin
                    if (!done) begin
                        rem <= rem - b_r;
                        acc <= acc + C_ACC_ONE;
                    end
                end
                default: ;
            endcase
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder
// Description : Request FSM, arming logic, ROM interface and output
//               registers servicing the controller's A/B/RESTO/C enables.
//               Optional macro ALU_RESP_ERR_EN adds the div_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_responder
    import alu_resp_pkg::*;
#(
    parameter int ROM_AW = DEF_ROM_AW,
    parameter int DW     = DEF_DW
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_responder_if.slave   bus,
    output logic [ROM_AW-1:0] rom_addr,
    input  wire logic [DW-1:0] rom_data,
    output logic [DW-1:0]    a_q,
    output logic [DW-1:0]    b_q,
    output logic [2*DW-1:0]  quociente,
    output logic [DW-1:0]    resto_q,
`ifdef ALU_RESP_ERR_EN
    output logic             div_err,
`endif
    output logic [2*DW-1:0]  c_q
);

    state_t          state;
    op_t             op_q;
    logic            armed_a, armed_b, armed_resto, armed_c;
    logic            req_a, req_b, req_resto, req_c;
    logic            md_start, md_busy, md_done;
    logic [2*DW-1:0] md_acc;
    logic [DW-1:0]   md_rem;

    assign req_a     = bus.en_a     && armed_a;
    assign req_b     = bus.en_b     && armed_b;
    assign req_resto = bus.en_resto && armed_resto;
    assign req_c     = bus.en_c     && armed_c;

    assign md_start  = (state == S_CAP_B) && !md_busy;
    assign quociente = md_acc;

    iter_muldiv #(.DW(DW)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (op_q),
        .a     (a_q),
        .b     (rom_data),
        .busy  (md_busy),
        .done  (md_done),
        .acc   (md_acc),
        .rem   (md_rem)
    );

    // Request FSM with arming, ROM addressing, output latches and done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= OP_ADD;
            armed_a       <= 1'b1;
            armed_b       <= 1'b1;
            armed_resto   <= 1'b1;
            armed_c       <= 1'b1;
            rom_addr      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            resto_q       <= '0;
            c_q           <= '0;
            bus.fim_a     <= 1'b0;
            bus.fim_b     <= 1'b0;
            bus.fim_resto <= 1'b0;
            bus.fim_c     <= 1'b0;
`ifdef ALU_RESP_ERR_EN
            div_err       <= 1'b0;
`endif
        end else begin
            bus.fim_a     <= 1'b0;
            bus.fim_b     <= 1'b0;
            bus.fim_resto <= 1'b0;
            bus.fim_c     <= 1'b0;

            // A low enable re-arms its request; acceptance below disarms it.
            if (!bus.en_a)     armed_a     <= 1'b1;
            if (!bus.en_b)     armed_b     <= 1'b1;
            if (!bus.en_resto) armed_resto <= 1'b1;
            if (!bus.en_c)     armed_c     <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (req_a) begin
                        armed_a  <= 1'b0;
                        rom_addr <= bus.endereco;
                        state    <= S_RD_A;
                    end else if (req_b) begin
                        armed_b  <= 1'b0;
                        rom_addr <= bus.endereco;
                        op_q     <= op_t'(bus.op_sel);
`ifdef ALU_RESP_ERR_EN
                        div_err  <= 1'b0;
`endif
                        state    <= S_RD_B;
                    end else if (req_resto) begin
                        armed_resto <= 1'b0;
                        state       <= S_RESTO;
                    end else if (req_c) begin
                        armed_c <= 1'b0;
                        state   <= S_WR_C;
                    end
                end
                S_RD_A:  state <= S_CAP_A;
                S_CAP_A: begin
                    a_q       <= rom_data;
                    bus.fim_a <= 1'b1;
                    state     <= S_IDLE;
                end
                S_RD_B:  state <= S_CAP_B;
                S_CAP_B: begin
                    b_q   <= rom_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (md_done) begin
                        bus.fim_b <= 1'b1;
                        state     <= S_IDLE;
`ifdef ALU_RESP_ERR_EN
                        if (op_q == OP_DIV && b_q == '0) begin
                            div_err <= 1'b1;
                        end
`endif
                    end
                end
                S_RESTO: begin
                    resto_q       <= md_rem;
                    bus.fim_resto <= 1'b1;
                    state         <= S_IDLE;
                end
                S_WR_C: begin
                    c_q       <= md_acc;
                    bus.fim_c <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_responder
// Description : Directed self-checking bench for alu_responder with a
//               synchronous operand ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_responder;

    logic        clk;
    logic        rst_n;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  a_q, b_q, resto_q;
    logic [15:0] quociente, c_q;
`ifdef ALU_RESP_ERR_EN
    logic        div_err;
`endif

    logic [7:0]  rom [0:511];
    int          errors = 0;
    int          checks = 0;
    int          n_fim_a = 0;
    int          n_fim_b = 0;
    int          n_multi = 0;

    alu_responder_if #(.ROM_AW(9)) bus ();

    alu_responder #(.ROM_AW(9), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .a_q       (a_q),
        .b_q       (b_q),
        .quociente (quociente),
        .resto_q   (resto_q),
`ifdef ALU_RESP_ERR_EN
        .div_err   (div_err),
`endif
        .c_q       (c_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.fim_a) n_fim_a++;
        if (bus.fim_b) n_fim_b++;
        if ((32'(bus.fim_a) + 32'(bus.fim_b) + 32'(bus.fim_resto) + 32'(bus.fim_c)) > 1)
            n_multi++;
    end

    function automatic logic fim_of(input int which);
        case (which)
            0:       return bus.fim_a;
            1:       return bus.fim_b;
            2:       return bus.fim_resto;
            default: return bus.fim_c;
        endcase
    endfunction

    // Raise one enable, wait for its fim (bounded), drop the enable.
    // lat = edges after acceptance until fim is seen; -1 on timeout.
    task automatic request(input int which, input logic [8:0] addr,
                           input logic [1:0] op, output int lat);
        lat = -1;
        bus.endereco = addr;
        bus.op_sel   = op;
        case (which)
            0:       bus.en_a     = 1'b1;
            1:       bus.en_b     = 1'b1;
            2:       bus.en_resto = 1'b1;
            default: bus.en_c     = 1'b1;
        endcase
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (fim_of(which)) begin
                lat = i - 1;
                break;
            end
        end
        case (which)
            0:       bus.en_a     = 1'b0;
            1:       bus.en_b     = 1'b0;
            2:       bus.en_resto = 1'b0;
            default: bus.en_c     = 1'b0;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (quociente !== 16'd0 || c_q !== 16'd0 || a_q !== 8'd0 || b_q !== 8'd0 || resto_q !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: q=%0d c=%0d a=%0d b=%0d r=%0d, required all 0", quociente, c_q, a_q, b_q, resto_q);
        end
        checks++;
        if ({bus.fim_a, bus.fim_b, bus.fim_resto, bus.fim_c} !== 4'b0 || rom_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_fim_addr: fims=%b addr=%0d, required 0", {bus.fim_a, bus.fim_b, bus.fim_resto, bus.fim_c}, rom_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        request(0, 9'd0, 2'b00, lat);
        checks++;
        if (lat !== 2 || a_q !== 8'd7) begin
            errors++;
            $display("FAIL add_capture_a: lat=%0d a_q=%0d, required lat=2 a_q=7", lat, a_q);
        end
        request(1, 9'd2, 2'b00, lat);
        checks++;
        if (lat !== 3 || quociente !== 16'd12 || b_q !== 8'd5) begin
            errors++;
            $display("FAIL add_exec: lat=%0d q=%0d b_q=%0d, required lat=3 q=12 b_q=5", lat, quociente, b_q);
        end
        request(3, 9'd0, 2'b00, lat);
        checks++;
        if (lat !== 1 || c_q !== 16'd12) begin
            errors++;
            $display("FAIL add_wr_c: lat=%0d c_q=%0d, required lat=1 c_q=12", lat, c_q);
        end
        request(2, 9'd0, 2'b00, lat);
        checks++;
        if (lat !== 1 || resto_q !== 8'd0) begin
            errors++;
            $display("FAIL add_resto: lat=%0d resto_q=%0d, required lat=1 resto_q=0", lat, resto_q);
        end
    endtask

    task automatic test_sub();
        int lat;
        request(0, 9'd3, 2'b00, lat);
        request(1, 9'd2, 2'b01, lat);
        checks++;
        if (lat !== 3 || quociente !== 16'hFFFE) begin
            errors++;
            $display("FAIL sub_wrap: lat=%0d q=%h, required lat=3 q=fffe", lat, quociente);
        end
    endtask

    task automatic test_mul();
        int lat;
        request(0, 9'd4, 2'b00, lat);
        request(1, 9'd4, 2'b10, lat);
        checks++;
        if (lat !== 257 || quociente !== 16'd65025) begin
            errors++;
            $display("FAIL mul_255x255: lat=%0d q=%0d, required lat=257 q=65025", lat, quociente);
        end
        request(1, 9'd5, 2'b10, lat);
        checks++;
        if (lat !== 3 || quociente !== 16'd0) begin
            errors++;
            $display("FAIL mul_by_zero: lat=%0d q=%0d, required lat=3 q=0", lat, quociente);
        end
    endtask

    task automatic test_div();
        int lat;
        request(0, 9'd6, 2'b00, lat);
        request(1, 9'd7, 2'b11, lat);
        checks++;
        if (lat !== 31 || quociente !== 16'd28) begin
            errors++;
            $display("FAIL div_200_7: lat=%0d q=%0d, required lat=31 q=28", lat, quociente);
        end
        request(2, 9'd0, 2'b00, lat);
        checks++;
        if (resto_q !== 8'd4) begin
            errors++;
            $display("FAIL div_resto: resto_q=%0d, required 4", resto_q);
        end
`ifdef ALU_RESP_ERR_EN
        checks++;
        if (div_err !== 1'b0) begin
            errors++;
            $display("FAIL div_err_clear: div_err=%b, required 0", div_err);
        end
`endif
        request(1, 9'd5, 2'b11, lat);
        checks++;
        if (lat !== 3 || quociente !== 16'd0) begin
            errors++;
            $display("FAIL div_by_zero: lat=%0d q=%0d, required lat=3 q=0", lat, quociente);
        end
`ifdef ALU_RESP_ERR_EN
        checks++;
        if (div_err !== 1'b1) begin
            errors++;
            $display("FAIL div_err_set: div_err=%b, required 1", div_err);
        end
`endif
        request(2, 9'd0, 2'b00, lat);
        checks++;
        if (resto_q !== 8'd200) begin
            errors++;
            $display("FAIL div0_resto: resto_q=%0d, required 200", resto_q);
        end
    endtask

    task automatic test_priority();
        int a_at = -1;
        int c_at = -1;
        bus.endereco = 9'd0;
        bus.en_a = 1'b1;
        bus.en_c = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.fim_a) a_at = i - 1;
            if (bus.fim_c) c_at = i - 1;
        end
        bus.en_a = 1'b0;
        bus.en_c = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_at !== 2 || c_at !== 4) begin
            errors++;
            $display("FAIL priority_a_then_c: fim_a at %0d fim_c at %0d, required 2 and 4", a_at, c_at);
        end
        checks++;
        if (a_q !== 8'd7 || c_q !== 16'd0) begin
            errors++;
            $display("FAIL priority_values: a_q=%0d c_q=%0d, required 7 and 0", a_q, c_q);
        end
    endtask

    task automatic test_held_enable();
        int lat;
        int fa0;
        fa0 = n_fim_a;
        bus.endereco = 9'd3;
        bus.en_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        request(1, 9'd2, 2'b00, lat);
        request(3, 9'd0, 2'b00, lat);
        request(2, 9'd0, 2'b00, lat);
        bus.en_a = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ((n_fim_a - fa0) !== 1) begin
            errors++;
            $display("FAIL held_single_fim: fim_a pulses=%0d, required 1", n_fim_a - fa0);
        end
        checks++;
        if (a_q !== 8'd3 || quociente !== 16'd8 || c_q !== 16'd8) begin
            errors++;
            $display("FAIL held_values: a_q=%0d q=%0d c_q=%0d, required 3 8 8", a_q, quociente, c_q);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int fb0;
        request(0, 9'd0, 2'b00, lat);
        fb0 = n_fim_b;
        bus.endereco = 9'd8;
        bus.op_sel   = 2'b10;
        bus.en_b     = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        bus.en_b = 1'b0;
        #1;
        checks++;
        if (quociente !== 16'd0 || a_q !== 8'd0 || b_q !== 8'd0 || c_q !== 16'd0 || bus.fim_b !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: q=%0d a=%0d b=%0d c=%0d fim_b=%b, required all 0", quociente, a_q, b_q, c_q, bus.fim_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (n_fim_b !== fb0) begin
            errors++;
            $display("FAIL rst_mid_no_fim: fim_b pulses=%0d, required 0", n_fim_b - fb0);
        end
        request(0, 9'd0, 2'b00, lat);
        request(1, 9'd2, 2'b10, lat);
        checks++;
        if (lat !== 7 || quociente !== 16'd35) begin
            errors++;
            $display("FAIL rst_mid_fresh_mul: lat=%0d q=%0d, required lat=7 q=35", lat, quociente);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 8'd0;
        rom[0] = 8'd7;
        rom[2] = 8'd5;
        rom[3] = 8'd3;
        rom[4] = 8'd255;
        rom[5] = 8'd0;
        rom[6] = 8'd200;
        rom[7] = 8'd7;
        rom[8] = 8'd100;
        bus.en_a     = 1'b0;
        bus.en_b     = 1'b0;
        bus.en_resto = 1'b0;
        bus.en_c     = 1'b0;
        bus.op_sel   = 2'b00;
        bus.endereco = 9'd0;

        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_priority();
        test_held_enable();
        test_reset_mid_mul();

        checks++;
        if (n_multi !== 0) begin
            errors++;
            $display("FAIL fim_exclusive: cycles with >1 fim=%0d, required 0", n_multi);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
